// File: rtl/carbon_tier_ctrl.sv
// carbon_tier_ctrl: MODEUP/RETMD tier-transition responder for CarbonZ80.
// Keeps the current tier CSR and a mode-descriptor stack of {prev tier, return PC}.
// Each accepted request is validated and committed in one EXEC cycle and answered
// with either a completed transition or a trap cause.
// Optional build macro: CARBON_TIER_CTRL_LATERAL_EN (equal-tier MODEUP becomes legal).
module carbon_tier_ctrl #(
  parameter int unsigned MD_DEPTH   = 4,
  parameter int unsigned RESET_TIER = 0,
  parameter int unsigned MAX_TIER   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [7:0]  req_tier,
  input  logic [15:0] req_ret_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_ok,
  output logic [15:0] rsp_pc,
  output logic [31:0] rsp_cause,
  output logic [7:0]  tier_o,
  output logic [3:0]  md_sp_o,
  output logic        trapped_o
);

  localparam int unsigned AW       = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam logic [7:0]  MAX_T    = 8'(MAX_TIER);
  localparam logic [7:0]  RST_T    = 8'(RESET_TIER);
  localparam logic [3:0]  DEPTH_SP = 4'(MD_DEPTH);

  localparam logic [31:0] CAUSE_TIER  = 32'h0000_0012;
  localparam logic [31:0] CAUSE_UNDER = 32'h0000_0013;
  localparam logic [31:0] CAUSE_FULL  = 32'h0000_0014;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t        state;
  logic          op_q;
  logic [7:0]    tier_q;
  logic [15:0]   pc_q;

  logic [7:0]    stk_tier [MD_DEPTH];
  logic [15:0]   stk_pc   [MD_DEPTH];

  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;
  logic          tier_bad;
  logic          stk_full;
  logic          stk_empty;
  logic          do_push;
  logic          do_pop;
  logic [31:0]   trap_cause;

  // Validate the latched request against current tier and stack occupancy
  always_comb begin
    push_idx   = AW'(md_sp_o);
    pop_idx    = AW'(md_sp_o - 4'd1);
    stk_full   = (md_sp_o >= DEPTH_SP);
    stk_empty  = (md_sp_o == 4'd0);
`ifdef CARBON_TIER_CTRL_LATERAL_EN
    tier_bad   = (tier_q < tier_o) || (tier_q > MAX_T);
`else
    tier_bad   = (tier_q <= tier_o) || (tier_q > MAX_T);
`endif
    do_push    = 1'b0;
    do_pop     = 1'b0;
    trap_cause = '0;
    if (op_q) begin
      if (stk_empty) trap_cause = CAUSE_UNDER;
      else           do_pop     = 1'b1;
    end else begin
      // tier check has priority over the full check
      if (tier_bad)      trap_cause = CAUSE_TIER;
      else if (stk_full) trap_cause = CAUSE_FULL;
      else               do_push    = 1'b1;
    end
  end

  // MD stack storage; contents are don't-care above md_sp_o so no reset needed
  always_ff @(posedge clk) begin
    if (state == S_EXEC && do_push) begin
      stk_tier[push_idx] <= tier_o;
      stk_pc[push_idx]   <= pc_q;
    end
  end

  // Request/response FSM with registered handshake, response and CSR outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= 1'b0;
      tier_q    <= '0;
      pc_q      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_pc    <= '0;
      rsp_cause <= '0;
      tier_o    <= RST_T;
      md_sp_o   <= '0;
      trapped_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            tier_q    <= req_tier;
            pc_q      <= req_ret_pc;
            req_ready <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_ok    <= do_push | do_pop;
          rsp_cause <= trap_cause;
          rsp_pc    <= do_pop ? stk_pc[pop_idx] : '0;
          if (do_push) begin
            md_sp_o <= md_sp_o + 4'd1;
            tier_o  <= tier_q;
          end else if (do_pop) begin
            md_sp_o <= md_sp_o - 4'd1;
            tier_o  <= stk_tier[pop_idx];
          end else begin
            trapped_o <= 1'b1;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carbon_tier_ctrl.sv
// Self-checking bench for carbon_tier_ctrl: a queue-based tier/stack model predicts
// every visible output each cycle; directed literals pin the model on key scenarios.
// MAX_TIER is raised above MD_DEPTH so the stack can actually be filled by strictly
// increasing MODEUPs.
module tb_carbon_tier_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXT  = 5;
`ifdef CARBON_TIER_CTRL_LATERAL_EN
  localparam bit LATERAL = 1'b1;
`else
  localparam bit LATERAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [7:0]  req_tier = '0;
  logic [15:0] req_ret_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_ok;
  logic [15:0] rsp_pc;
  logic [31:0] rsp_cause;
  logic [7:0]  tier_o;
  logic [3:0]  md_sp_o;
  logic        trapped_o;

  always #5 clk = ~clk;

  carbon_tier_ctrl #(.MD_DEPTH(DEPTH), .RESET_TIER(0), .MAX_TIER(MAXT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tier(req_tier), .req_ret_pc(req_ret_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
    .rsp_pc(rsp_pc), .rsp_cause(rsp_cause),
    .tier_o(tier_o), .md_sp_o(md_sp_o), .trapped_o(trapped_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // architectural model
  int          m_tier;
  int unsigned m_tiers[$];
  int unsigned m_pcs[$];
  bit          m_trapped;

  // expected visible outputs, updated by the driver just after each active edge
  bit          chk_en = 1'b0;
  bit          e_ready, e_rvalid, e_ok, e_trapped;
  logic [15:0] e_pc;
  logic [31:0] e_cause;
  int          e_tier, e_sp;

  // last response as seen on the DUT, for literal pinning
  logic        last_ok;
  logic [15:0] last_pc;
  logic [31:0] last_cause;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tier = 0;
    m_tiers.delete();
    m_pcs.delete();
    m_trapped = 1'b0;
    e_ready = 1'b1; e_rvalid = 1'b0; e_ok = 1'b0; e_trapped = 1'b0;
    e_pc = '0; e_cause = '0; e_tier = 0; e_sp = 0;
  endtask

  task automatic model_exec(input bit op, input int t, input int unsigned pc,
                            output bit ok, output logic [15:0] rpc, output logic [31:0] cause);
    ok = 1'b0; rpc = '0; cause = '0;
    if (!op) begin
      if (t < m_tier || t > int'(MAXT) || (t == m_tier && !LATERAL)) cause = 32'h12;
      else if (m_tiers.size() == DEPTH) cause = 32'h14;
      else begin
        m_tiers.push_back(m_tier);
        m_pcs.push_back(pc);
        m_tier = t;
        ok = 1'b1;
      end
    end else begin
      if (m_tiers.size() == 0) cause = 32'h13;
      else begin
        m_tier = m_tiers.pop_back();
        rpc = 16'(m_pcs.pop_back());
        ok = 1'b1;
      end
    end
    if (!ok) m_trapped = 1'b1;
  endtask

  // per-cycle comparison of every visible output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rvalid));
      check("tier_o",    32'(tier_o),    32'(e_tier));
      check("md_sp_o",   32'(md_sp_o),   32'(e_sp));
      check("trapped_o", 32'(trapped_o), 32'(e_trapped));
      if (e_rvalid) begin
        check("rsp_ok",    32'(rsp_ok),    32'(e_ok));
        check("rsp_pc",    32'(rsp_pc),    32'(e_pc));
        check("rsp_cause", rsp_cause,      e_cause);
      end
    end
  end

  // one full request/response; hold = cycles rsp_ready stays low in RESP
  task automatic do_req(input bit op, input int t, input int unsigned pc, input int hold);
    bit          ok;
    logic [15:0] rpc;
    logic [31:0] cause;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_tier = 8'(t); req_ret_pc = 16'(pc);
    @(posedge clk); #1;
    // junk on the request bus while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_op = 1'($urandom); req_tier = 8'($urandom); req_ret_pc = 16'($urandom);
    e_ready = 1'b0;
    model_exec(op, t, pc, ok, rpc, cause);
    @(posedge clk); #1;
    e_rvalid = 1'b1; e_ok = ok; e_pc = rpc; e_cause = cause;
    e_tier = m_tier; e_sp = m_tiers.size(); e_trapped = m_trapped;
    last_ok = rsp_ok; last_pc = rsp_pc; last_cause = rsp_cause;
    if (hold > 0) begin
      req_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    e_rvalid = 1'b0; e_ready = 1'b1;
  endtask

  initial begin
    bit op;
    int t;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tier",    32'(tier_o),    32'd0);
    check("rst_sp",      32'(md_sp_o),   32'd0);
    check("rst_ready",   32'(req_ready), 32'd1);
    check("rst_trapped", 32'(trapped_o), 32'd0);
    check("rst_rvalid",  32'(rsp_valid), 32'd0);

    // basic MODEUP / RETMD round trip
    do_req(1'b0, 1, 16'h1234, 0);
    check("lit_up1_ok", 32'(last_ok), 32'd1);
    check("lit_up1_tier", 32'(tier_o), 32'd1);
    check("lit_up1_sp", 32'(md_sp_o), 32'd1);
    do_req(1'b1, 0, 0, 0);
    check("lit_ret_ok", 32'(last_ok), 32'd1);
    check("lit_ret_pc", 32'(last_pc), 32'h1234);
    check("lit_ret_tier", 32'(tier_o), 32'd0);
    check("lit_ret_sp", 32'(md_sp_o), 32'd0);

    // 0 -> 2 and back
    do_req(1'b0, 2, 16'hBEEF, 0);
    check("lit_up2_tier", 32'(tier_o), 32'd2);
    check("lit_up2_sp", 32'(md_sp_o), 32'd1);
    do_req(1'b1, 0, 0, 0);
    check("lit_ret2_pc", 32'(last_pc), 32'hBEEF);
    check("lit_ret2_tier", 32'(tier_o), 32'd0);

    // out-of-range tier trap
    do_req(1'b0, MAXT + 1, 16'h0001, 0);
    check("lit_bad_ok", 32'(last_ok), 32'd0);
    check("lit_bad_cause", last_cause, 32'h12);
    check("lit_bad_trapped", 32'(trapped_o), 32'd1);
    check("lit_bad_tier", 32'(tier_o), 32'd0);

    // underflow trap
    do_req(1'b1, 0, 0, 0);
    check("lit_under_cause", last_cause, 32'h13);

    // fill the stack, then overflow
    for (int i = 1; i <= int'(DEPTH); i++) do_req(1'b0, i, 16'(16'h1000 + i), 0);
    check("lit_fill_sp", 32'(md_sp_o), 32'(DEPTH));
    do_req(1'b0, MAXT, 16'h2222, 0);
    check("lit_full_cause", last_cause, 32'h14);
    check("lit_full_sp", 32'(md_sp_o), 32'(DEPTH));
    // lower tier while full: tier cause has priority
    do_req(1'b0, 1, 16'h3333, 0);
    check("lit_both_cause", last_cause, 32'h12);
    // equal tier while full (cause depends on lateral build; model decides)
    do_req(1'b0, DEPTH, 16'h4444, 0);

    // response held for 5 clocks
    do_req(1'b1, 0, 0, 5);
    check("lit_hold_pc", 32'(last_pc), 32'(16'h1000 + DEPTH));
    check("lit_hold_sp", 32'(md_sp_o), 32'(DEPTH - 1));

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) < 4);
      t  = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, MAXT + 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(op, t, $urandom_range(0, 16'hFFFF), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // reset asserted during EXEC aborts the transaction
    do_req(1'b1, 0, 0, 0);
    do_req(1'b0, 7, 0, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_tier = 8'd1; req_ret_pc = 16'h5555;
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    model_reset();
    #1;
    check("lit_arst_tier", 32'(tier_o), 32'd0);
    check("lit_arst_sp", 32'(md_sp_o), 32'd0);
    check("lit_arst_trapped", 32'(trapped_o), 32'd0);
    check("lit_arst_rvalid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // normal operation after reset
    do_req(1'b0, 1, 16'hCAFE, 0);
    do_req(1'b1, 0, 0, 0);
    check("lit_post_pc", 32'(last_pc), 32'hCAFE);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
